axi4_mem_master: RTL and testbench
==================================

// Module: axi4_mem_master
// PURPOSE
//  AXI4 master-side bridge between a simple single-outstanding request port (IFU/LSU arbiter) and the
//  core's io_master AXI4 bus. Converts one request into either an INCR read burst (cache refill) or a
//  single-beat write, returning read beats and write completion on a response port.
//  One transaction in flight at a time; this is the initiator for the simulation memory/device slave.
// PARAMETERS
//  AXI_ID      4'h0   value driven on awid/arid
//  DATA_W      32     data width; arsize/awsize fixed to 3'b010 (4 bytes)
// PORTS
//  clock             in   1   system clock
//  reset             in   1   synchronous, active-high
//  req_valid         in   1   request offered
//  req_ready         out  1   request accepted when req_valid&req_ready
//  req_write         in   1   1=write (single beat), 0=read
//  req_addr          in   32  byte address (word aligned)
//  req_len           in   8   read beats minus 1 (ignored for writes)
//  req_wdata         in   32  write data
//  req_wstrb         in   4   write byte strobes
//  resp_valid        out  1   one read beat or write completion; no backpressure
//  resp_data         out  32  read beat data (0 for writes)
//  resp_last         out  1   final beat of read / always 1 for write completion
//  resp_err          out  1   rresp/bresp!=0, or rlast/beat-count mismatch
//  io_master_aw*     out      awvalid, awaddr[32], awid[4], awlen[8]=0, awsize[3]=2, awburst[2]=01; awready in
//  io_master_w*      out      wvalid, wdata[32], wstrb[4], wlast=1; wready in
//  io_master_b*      bready out; bvalid, bresp[2], bid[4] in
//  io_master_ar*     out      arvalid, araddr[32], arid[4], arlen[8], arsize[3]=2, arburst[2]=01; arready in
//  io_master_r*      rready out; rvalid, rdata[32], rresp[2], rlast, rid[4] in
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready=1; awvalid=wvalid=arvalid=bready=rready=0; resp_valid=0;
//    resp_data=0, resp_last=0, resp_err=0; beat counter=0.
//  - FSM: IDLE, RD_AR, RD_R, WR_AW_W, WR_B.
//  - IDLE: req_ready=1. On accept, latch addr/len/wdata/wstrb; read -> RD_AR, write -> WR_AW_W.
//    req_ready=0 in every other state; next request accepted at earliest the cycle after return to IDLE.
//  - RD_AR: arvalid=1, araddr/arlen from latch, held stable until arvalid&arready -> RD_R, cnt=len.
//  - RD_R: rready=1. Each rvalid beat: resp_valid=1 next cycle (registered, latency 1) with rdata;
//    resp_err=(rresp!=0)|(rlast!=(cnt==0)). cnt decrements per beat. Beat with cnt==0 ends burst:
//    resp_last=1, -> IDLE. rlast asserted early is flagged via resp_err but transfer continues to len+1 beats.
//  - WR_AW_W: awvalid and wvalid both raised on entry; each deasserts independently after its own
//    handshake (aw_done/w_done flags). Either order, or same cycle, is legal. Both done -> WR_B.
//    Never wait for awready before wvalid, nor vice versa.
//  - WR_B: bready=1; on bvalid -> resp_valid=1 next cycle, resp_last=1, resp_data=0,
//    resp_err=(bresp!=0); -> IDLE.
//  - resp_valid is a 1-cycle pulse per beat/completion; resp_data/last/err hold until next pulse.
//  - AXI stability: once a *valid is high its payload does not change until handshake.
//  - rid/bid not checked (single outstanding).
//  - reset mid-transaction: immediate return to IDLE with reset values; no in-flight beat reported.
// TESTING
//  - Read len=3 @0x80000010, slave rvalid each cycle -> 4 resp pulses, data in order, resp_last on 4th, err=0.
//  - Write 0xDEADBEEF strb 4'b0011 @0x80000100, awready 2 cycles before wready -> aw/w each 1 handshake, one resp, last=1.
//  - Write with wready before awready, and with both same cycle -> identical single completion, no duplicate valids.
//  - Read len=0 with slave rresp=2'b10 and 3-cycle arready stall -> araddr stable while stalled, one resp, err=1.
//  - Read len=2, slave asserts rlast on beat 1 -> err=1 on beat 1, 3 beats delivered, returns IDLE.
//  - Reset asserted during RD_R beat 2 of 4 -> next cycle all valids 0, req_ready=1, new read completes normally.

Source files
------------

// File: rtl/axi4_mem_master.sv
// -----------------------------------------------------------------------------
// axi4_mem_master
//
// Purpose:
//   AXI4 master-side bridge between a single-outstanding request port (the
//   IFU/LSU arbiter) and the core's io_master AXI4 bus. A read request becomes
//   one INCR burst of req_len+1 beats; a write request becomes a single-beat
//   write. Read beats and write completions come back on the response port,
//   registered, one cycle after the AXI handshake that produced them.
//
// Ports:
//   clock, reset              system clock, synchronous active-high reset
//   req_valid/ready           request handshake (ready only while idle)
//   req_write                 1 = single-beat write, 0 = read burst
//   req_addr, req_len         word-aligned byte address, read beats minus 1
//   req_wdata, req_wstrb      write payload
//   resp_valid                1-cycle pulse per read beat / write completion
//   resp_data/last/err        response payload, held between pulses
//   io_master_aw*/w*/b*       AXI4 write address, write data, write response
//   io_master_ar*/r*          AXI4 read address, read data
// -----------------------------------------------------------------------------
module axi4_mem_master #(
  parameter logic [3:0] AXI_ID = 4'h0,
  parameter int         DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  // request port
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [7:0]            req_len,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  // response port
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_data,
  output logic                  resp_last,
  output logic                  resp_err,
  // AXI4 write address channel
  output logic                  io_master_awvalid,
  input  logic                  io_master_awready,
  output logic [31:0]           io_master_awaddr,
  output logic [3:0]            io_master_awid,
  output logic [7:0]            io_master_awlen,
  output logic [2:0]            io_master_awsize,
  output logic [1:0]            io_master_awburst,
  // AXI4 write data channel
  output logic                  io_master_wvalid,
  input  logic                  io_master_wready,
  output logic [DATA_W-1:0]     io_master_wdata,
  output logic [DATA_W/8-1:0]   io_master_wstrb,
  output logic                  io_master_wlast,
  // AXI4 write response channel
  output logic                  io_master_bready,
  input  logic                  io_master_bvalid,
  input  logic [1:0]            io_master_bresp,
  input  logic [3:0]            io_master_bid,
  // AXI4 read address channel
  output logic                  io_master_arvalid,
  input  logic                  io_master_arready,
  output logic [31:0]           io_master_araddr,
  output logic [3:0]            io_master_arid,
  output logic [7:0]            io_master_arlen,
  output logic [2:0]            io_master_arsize,
  output logic [1:0]            io_master_arburst,
  // AXI4 read data channel
  output logic                  io_master_rready,
  input  logic                  io_master_rvalid,
  input  logic [DATA_W-1:0]     io_master_rdata,
  input  logic [1:0]            io_master_rresp,
  input  logic                  io_master_rlast,
  input  logic [3:0]            io_master_rid
);

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW_W, WR_B} state_e;

  state_e                state_q;
  logic [31:0]           addr_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;

  logic                  req_ready_q;
  logic                  awvalid_q, wvalid_q, bready_q;
  logic                  arvalid_q, rready_q;
  logic                  resp_valid_q, resp_last_q, resp_err_q;
  logic [DATA_W-1:0]     resp_data_q;

  // Next-cycle helpers. A write channel counts as done once its valid has
  // dropped, or if its handshake completes this cycle.
  logic                  aw_done_d, w_done_d, beat_err_d;

  // IDs are not checked: only one transaction is ever outstanding.
  logic                  unused_ids;
  assign unused_ids = ^{io_master_bid, io_master_rid};

  assign aw_done_d  = !awvalid_q || io_master_awready;
  assign w_done_d   = !wvalid_q  || io_master_wready;
  assign beat_err_d = (io_master_rresp != 2'b00) || (io_master_rlast != (cnt_q == 8'd0));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      req_ready_q  <= 1'b1;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_last_q  <= 1'b0;
      resp_err_q   <= 1'b0;
      // NOTE: addr/len/wdata/wstrb are left out of reset on purpose; they are
      // only ever seen on the bus behind a valid that reset clears.
    end else begin
      // NOTE: all state here uses non-blocking assignments so every branch
      // reads the pre-edge value; the pulse default below relies on that.
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q      <= req_addr;
            len_q       <= req_len;
            wdata_q     <= req_wdata;
            wstrb_q     <= req_wstrb;
            req_ready_q <= 1'b0;
            if (req_write) begin
              // Both write channels are raised together; neither waits on the other.
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_AW_W;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_AR;
            end
          end
        end
        RD_AR: begin
          if (io_master_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            cnt_q     <= len_q;
            state_q   <= RD_R;
          end
        end
        RD_R: begin
          if (io_master_rvalid) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= io_master_rdata;
            resp_last_q  <= (cnt_q == 8'd0);
            resp_err_q   <= beat_err_d;
            // The beat count, not rlast, ends the burst; an early rlast is
            // only reported through resp_err.
            if (cnt_q == 8'd0) begin
              rready_q    <= 1'b0;
              req_ready_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        WR_AW_W: begin
          if (io_master_awready) awvalid_q <= 1'b0;
          if (io_master_wready)  wvalid_q  <= 1'b0;
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= WR_B;
          end
        end
        WR_B: begin
          if (io_master_bvalid) begin
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_data_q  <= '0;
            resp_last_q  <= 1'b1;
            resp_err_q   <= (io_master_bresp != 2'b00);
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready         = req_ready_q;
  assign resp_valid        = resp_valid_q;
  assign resp_data         = resp_data_q;
  assign resp_last         = resp_last_q;
  assign resp_err          = resp_err_q;

  assign io_master_awvalid = awvalid_q;
  assign io_master_awaddr  = addr_q;
  assign io_master_awid    = AXI_ID;
  assign io_master_awlen   = 8'd0;
  assign io_master_awsize  = 3'b010;
  assign io_master_awburst = 2'b01;

  assign io_master_wvalid  = wvalid_q;
  assign io_master_wdata   = wdata_q;
  assign io_master_wstrb   = wstrb_q;
  assign io_master_wlast   = 1'b1;
  assign io_master_bready  = bready_q;

  assign io_master_arvalid = arvalid_q;
  assign io_master_araddr  = addr_q;
  assign io_master_arid    = AXI_ID;
  assign io_master_arlen   = len_q;
  assign io_master_arsize  = 3'b010;
  assign io_master_arburst = 2'b01;
  assign io_master_rready  = rready_q;

endmodule

// File: tb/tb_axi4_mem_master.sv
// -----------------------------------------------------------------------------
// tb_axi4_mem_master
//
// Directed bench for axi4_mem_master. The bench plays the AXI slave cycle by
// cycle: inputs change 1 time unit after the rising edge, outputs are sampled
// at that same point, so every value seen reflects the preceding edge.
// -----------------------------------------------------------------------------
module tb_axi4_mem_master;

  logic        clock, reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_last, resp_err;
  logic [31:0] resp_data;
  logic        awvalid, awready, wvalid, wready, wlast, bready, bvalid;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awid, wstrb, bid, arid, rid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        arvalid, arready, rready, rvalid, rlast;

  int vectors     = 0;
  int miscompares = 0;

  axi4_mem_master #(.AXI_ID(4'h0), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last), .resp_err(resp_err),
    .io_master_awvalid(awvalid), .io_master_awready(awready), .io_master_awaddr(awaddr),
    .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize),
    .io_master_awburst(awburst),
    .io_master_wvalid(wvalid), .io_master_wready(wready), .io_master_wdata(wdata),
    .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_bready(bready), .io_master_bvalid(bvalid), .io_master_bresp(bresp),
    .io_master_bid(bid),
    .io_master_arvalid(arvalid), .io_master_arready(arready), .io_master_araddr(araddr),
    .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize),
    .io_master_arburst(arburst),
    .io_master_rready(rready), .io_master_rvalid(rvalid), .io_master_rdata(rdata),
    .io_master_rresp(rresp), .io_master_rlast(rlast), .io_master_rid(rid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_slave();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 4'h0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0; rid = 4'h0;
  endtask

  // Offer one request and let it be accepted on the next edge.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                       input logic [31:0] wd, input logic [3:0] ws);
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len;
    req_wdata = wd; req_wstrb = ws;
    tick();
    req_valid = 1'b0;
    check("req_ready_busy", 32'(req_ready), 32'd0);
  endtask

  // Read burst; rlast is driven on beat rlast_at (equal to len for a well-formed slave).
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input int stall,
                         input logic [1:0] rr, input int rlast_at, input logic [31:0] base);
    logic exp_err;
    issue(1'b0, addr, len, 32'h0, 4'h0);
    check("arvalid_up", 32'(arvalid), 32'd1);
    check("araddr", araddr, addr);
    check("arlen", 32'(arlen), 32'(len));
    check("ar_size_burst_id", {23'd0, arsize, arburst, arid}, {23'd0, 3'b010, 2'b01, 4'h0});
    for (int s = 0; s < stall; s++) begin
      arready = 1'b0;
      tick();
      check("arvalid_stall", 32'(arvalid), 32'd1);
      check("araddr_stall", araddr, addr);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("arvalid_down", 32'(arvalid), 32'd0);
    check("rready_up", 32'(rready), 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      rvalid = 1'b1; rdata = base + 32'(i); rresp = rr; rlast = (i == rlast_at);
      exp_err = (rr != 2'b00) || ((i == rlast_at) != (i == int'(len)));
      tick();
      check("rd_resp_valid", 32'(resp_valid), 32'd1);
      check("rd_resp_data", resp_data, base + 32'(i));
      check("rd_resp_last", 32'(resp_last), 32'(i == int'(len)));
      check("rd_resp_err", 32'(resp_err), 32'(exp_err));
    end
    idle_slave();
    check("rready_down", 32'(rready), 32'd0);
    check("rd_req_ready_back", 32'(req_ready), 32'd1);
    tick();
    check("rd_resp_pulse_end", 32'(resp_valid), 32'd0);
    check("rd_resp_data_hold", resp_data, base + 32'(len));
  endtask

  // Single-beat write; awready/wready rise (and stay up) after the given delays.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                          input int aw_delay, input int w_delay, input logic [1:0] br);
    int aw_hs = 0;
    int w_hs  = 0;
    logic saw_b = 1'b0;
    issue(1'b1, addr, 8'd0, wd, ws);
    check("wr_both_valid", {30'd0, awvalid, wvalid}, 32'd3);
    check("awaddr", awaddr, addr);
    check("aw_len_size_burst_id", {15'd0, awlen, awsize, awburst, awid},
          {15'd0, 8'd0, 3'b010, 2'b01, 4'h0});
    check("wdata", wdata, wd);
    check("wstrb_wlast", {27'd0, wstrb, wlast}, {27'd0, ws, 1'b1});
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (bready) begin
        saw_b = 1'b1;
        break;
      end
      awready = (cyc >= aw_delay);
      wready  = (cyc >= w_delay);
      if (awvalid && awready) aw_hs++;
      if (wvalid && wready)   w_hs++;
      tick();
    end
    awready = 1'b0; wready = 1'b0;
    check("bready_reached", 32'(saw_b), 32'd1);
    check("aw_handshakes", 32'(aw_hs), 32'd1);
    check("w_handshakes", 32'(w_hs), 32'd1);
    check("wr_no_early_resp", 32'(resp_valid), 32'd0);
    bvalid = 1'b1; bresp = br;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    check("bready_down", 32'(bready), 32'd0);
    check("wr_resp_valid", 32'(resp_valid), 32'd1);
    check("wr_resp_data", resp_data, 32'h0);
    check("wr_resp_last", 32'(resp_last), 32'd1);
    check("wr_resp_err", 32'(resp_err), 32'(br != 2'b00));
    check("wr_req_ready_back", 32'(req_ready), 32'd1);
    tick();
    check("wr_resp_pulse_end", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_len = 8'd0;
    req_wdata = 32'h0; req_wstrb = 4'h0;
    idle_slave();
    tick();
    tick();

    // Reset state
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_valids", {26'd0, awvalid, wvalid, bready, arvalid, rready, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_last_err", {30'd0, resp_last, resp_err}, 32'd0);
    reset = 1'b0;
    tick();

    // Read len=3, back-to-back beats
    do_read(32'h8000_0010, 8'd3, 0, 2'b00, 3, 32'h1111_0000);

    // Writes: aw first, w first, both together, then an error response
    do_write(32'h8000_0100, 32'hDEAD_BEEF, 4'b0011, 0, 2, 2'b00);
    do_write(32'h8000_0104, 32'hCAFE_F00D, 4'b1100, 2, 0, 2'b00);
    do_write(32'h8000_0108, 32'h0123_4567, 4'b1111, 1, 1, 2'b00);
    do_write(32'h8000_010C, 32'h89AB_CDEF, 4'b0001, 0, 0, 2'b10);

    // Read len=0, SLVERR, arready stalled 3 cycles
    do_read(32'h8000_0040, 8'd0, 3, 2'b10, 0, 32'h5555_AAAA);

    // Read len=2 with rlast on beat 1: errs 0,1,1 (final beat lacks rlast)
    do_read(32'h8000_0080, 8'd2, 0, 2'b00, 1, 32'h7777_0000);

    // Reset during beat 2 of a 4-beat read
    issue(1'b0, 32'h8000_0200, 8'd3, 32'h0, 4'h0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1; rdata = 32'h2222_0000 + 32'(i); rresp = 2'b00; rlast = 1'b0;
      tick();
      check("pre_rst_resp_valid", 32'(resp_valid), 32'd1);
    end
    rdata = 32'h2222_0002;
    reset = 1'b1;
    tick();
    idle_slave();
    check("midrst_valids", {26'd0, awvalid, wvalid, bready, arvalid, rready, resp_valid}, 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_resp_data", resp_data, 32'h0);
    check("midrst_resp_last_err", {30'd0, resp_last, resp_err}, 32'd0);
    reset = 1'b0;
    tick();
    do_read(32'h8000_0300, 8'd1, 0, 2'b00, 1, 32'h3333_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
